ifetch_ctrl: RTL and testbench
==============================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: fetch address loaded on reset (word aligned).
REQ-002 Parameter FETCH_DEPTH, default 2, meaning: instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  fetch enable; 1 = run, 0 = stop issuing new fetches.
REQ-006 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 rom_adr  output  32  byte address to instruction ROM (combinational read, ROM uses adr[7:2]).
REQ-009 rom_inst  input  32  ROM read data for rom_adr, same cycle.
REQ-010 inst_valid  output  1  buffer head holds a valid instruction.
REQ-011 inst_ready  input  1  downstream accepts head this cycle.
REQ-012 inst  output  32  instruction at buffer head.
REQ-013 inst_pc  output  32  byte address of inst.

Function
REQ-014 FSM states IDLE, RUN; IDLE -> RUN when en=1; RUN -> IDLE when en=0; redirect does not change state.
REQ-015 rom_adr SHALL equal fetch_pc at all times (combinational from register).
REQ-016 Push condition: state==RUN, redirect_valid==0, and (count<FETCH_DEPTH or pop this cycle).
REQ-017 On push: entry {fetch_pc, rom_inst} written to buffer tail; fetch_pc <= fetch_pc+4, wrapping modulo 2^32.
REQ-018 Pop condition: inst_valid && inst_ready; head removed at clock edge.
REQ-019 inst_valid = (count != 0); inst/inst_pc driven from head entry, combinational from buffer registers.
REQ-020 Pushed entry visible on inst_valid the cycle after push (1-cycle fetch latency).
REQ-021 Push and pop in same cycle SHALL leave count unchanged, including when full.
REQ-022 Full, no pop: no push, fetch_pc holds, rom_adr holds.
REQ-023 Empty: inst_valid=0; inst/inst_pc values don't-care.
REQ-024 Redirect: at edge, buffer flushed (count<=0), fetch_pc <= {redirect_pc[31:2],2'b00}; no push that cycle.
REQ-025 Redirect has priority over simultaneous push and pop; handshake on the head in a redirect cycle counts as consumed by downstream, buffer still flushed.
REQ-026 en=0 stops pushes from next state onward; buffered entries keep draining normally.
REQ-027 Redirect in IDLE updates fetch_pc and flushes; fetching resumes only when en=1.

Reset
REQ-028 On rst=1 at edge: state<=IDLE, fetch_pc<=RESET_PC, count/head/tail<=0.
REQ-029 After reset: rom_adr=RESET_PC, inst_valid=0; buffer data contents not reset.
REQ-030 rst mid-operation SHALL discard all buffered entries and override redirect_valid and en in that cycle.

Structure
REQ-031 Shared package fetch_pkg SHALL hold RESET_PC default, FETCH_DEPTH default, state enum {IDLE,RUN}, entry struct {pc[31:0], inst[31:0]}.
REQ-032 Buffer SHALL be sub-module fetch_fifo (sync FIFO, flush input, simultaneous push/pop when full); FSM and PC stay in ifetch_ctrl.
REQ-033 ROM is external; ifetch_ctrl SHALL not instantiate it.

Verification (ROM word i preloaded with 32'h1000_0000+i)
REQ-034 Reset, en=1 at cycle 0, inst_ready=1 -> inst_valid first high cycle 2, stream (pc,inst) = (0x00,0x10000000),(0x04,0x10000001),(0x08,0x10000002), one per cycle.
REQ-035 en=1, inst_ready=0 -> exactly 2 entries buffered, rom_adr holds 0x08; raise inst_ready -> entries 0x00,0x04,0x08 delivered without gap or duplicate.
REQ-036 Redirect_valid with redirect_pc=0x0000_0043 while buffer full -> next cycle inst_valid=0, rom_adr=0x40; following cycle inst_pc=0x40, inst=0x10000010.
REQ-037 Redirect pulse in same cycle as pop and push -> no stale entry delivered after redirect; count=0 next cycle.
REQ-038 fetch_pc driven to 0xFFFF_FFFC via redirect, en=1 -> inst_pc sequence 0xFFFFFFFC, 0x00000000 (wrap); inst = 0x1000003F then 0x10000000.
REQ-039 rst asserted with 2 entries buffered and en=1 -> next cycle inst_valid=0, rom_adr=RESET_PC, state IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller and its buffer.
package fetch_pkg;

   localparam int unsigned XLEN                = 32;
   localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
   localparam int unsigned FETCH_DEPTH_DEFAULT = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; accepts a push while full when the
// head is popped in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output fetch_entry_t head_entry,
   output logic         not_empty,
   output logic         full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign not_empty  = (count_q != '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   assign head_entry = mem_q[head_q];

   // Pointer/count update; flush wins over any push or pop in the same cycle.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      push_ok = 1'b0;
      pop_ok  = 1'b0;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         pop_ok  = pop && not_empty;
         push_ok = push && (!full || pop_ok);
         if (push_ok) tail_d = tail_q + PTR_W'(1);
         if (pop_ok)  head_d = head_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is intentionally not reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem_q[tail_q] <= push_entry;
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: run/idle FSM, fetch PC with redirect, and a
// small buffer decoupling the ROM from the downstream consumer.
module ifetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int unsigned FETCH_DEPTH = FETCH_DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] rom_adr,
   input  logic [31:0] rom_inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic         push;
   logic         pop;
   logic         fifo_full;
   logic         fifo_valid;
   fetch_entry_t push_entry;
   fetch_entry_t head_entry;

   assign rom_adr    = fetch_pc_q;
   assign inst_valid = fifo_valid;
   assign inst       = head_entry.inst;
   assign inst_pc    = head_entry.pc;

   assign pop  = fifo_valid && inst_ready;
   assign push = (state_q == RUN) && !redirect_valid && (!fifo_full || pop);

   always_comb begin
      push_entry      = '0;
      push_entry.pc   = fetch_pc_q;
      push_entry.inst = rom_inst;
   end

   // Next state and fetch PC; redirect leaves the state alone and suppresses the push.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      case (state_q)
         IDLE:    if (en)  state_d = RUN;
         RUN:     if (!en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FETCH_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .not_empty  (fifo_valid),
      .full       (fifo_full)
   );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a ROM model and an expected-delivery queue.
module tb_ifetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] rom_adr;
   logic [31:0] rom_inst;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   // ROM word i holds 32'h1000_0000 + i, addressed by adr[7:2].
   assign rom_inst = 32'h1000_0000 + {26'd0, rom_adr[7:2]};

   ifetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .rom_adr        (rom_adr),
      .rom_inst       (rom_inst),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ent(input logic [31:0] pc);
      return {pc, 32'h1000_0000 + {26'd0, pc[7:2]}};
   endfunction

   // Called at a falling edge with inputs already driven: scores any handshake
   // in the current cycle, then advances to the next falling edge.
   task automatic step();
      logic [63:0] e;
      #1;
      if (inst_valid && inst_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_delivery observed=%h expected=none", inst_pc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check32("deliver_pc", inst_pc, e[63:32]);
            check32("deliver_inst", inst, e[31:0]);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      @(negedge clk);
      step(); step();
      rst = 1'b0;
      // Reset state
      check32("rst_valid", 32'(inst_valid), 32'd0);
      check32("rst_adr", rom_adr, 32'h0);

      // Streaming from reset: first valid on cycle 2, then one per cycle
      en = 1'b1; inst_ready = 1'b1;
      exp_q.push_back(ent(32'h00)); exp_q.push_back(ent(32'h04)); exp_q.push_back(ent(32'h08));
      step();
      check32("c1_valid", 32'(inst_valid), 32'd0);
      step();
      check32("c2_valid", 32'(inst_valid), 32'd1);
      step(); step(); step();
      check32("stream_drained", 32'(exp_q.size()), 32'd0);

      // Backpressure from a fresh reset: two entries, fetch PC stalls at 0x08
      rst = 1'b1; inst_ready = 1'b0; step(); rst = 1'b0;
      step(); step(); step(); step();
      check32("full_valid", 32'(inst_valid), 32'd1);
      check32("full_adr", rom_adr, 32'h08);
      check32("full_head", inst_pc, 32'h00);
      step();
      check32("full_adr_hold", rom_adr, 32'h08);
      inst_ready = 1'b1;
      exp_q.push_back(ent(32'h00)); exp_q.push_back(ent(32'h04)); exp_q.push_back(ent(32'h08));
      step(); step(); step();
      check32("bp_drained", 32'(exp_q.size()), 32'd0);
      inst_ready = 1'b0;

      // Redirect while full (buffer holds 0x0C,0x10)
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
      step();
      redirect_valid = 1'b0;
      check32("redir_valid", 32'(inst_valid), 32'd0);
      check32("redir_adr", rom_adr, 32'h40);
      step();
      check32("redir_pc", inst_pc, 32'h40);
      check32("redir_inst", inst, 32'h1000_0010);
      inst_ready = 1'b1;
      exp_q.push_back(ent(32'h40));
      step();

      // Redirect coinciding with pop and push: head 0x44 consumed, 0x48 discarded
      exp_q.push_back(ent(32'h44));
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
      step();
      redirect_valid = 1'b0;
      check32("rpp_valid", 32'(inst_valid), 32'd0);
      check32("rpp_adr", rom_adr, 32'h80);
      exp_q.push_back(ent(32'h80));
      step(); step();

      // Wrap of the fetch PC past 0xFFFF_FFFC
      exp_q.push_back(ent(32'h84));
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      check32("wrap_adr", rom_adr, 32'hFFFF_FFFC);
      exp_q.push_back({32'hFFFF_FFFC, 32'h1000_003F});
      exp_q.push_back({32'h0000_0000, 32'h1000_0000});
      step(); step(); step();
      check32("wrap_drained", 32'(exp_q.size()), 32'd0);

      // Reset with two entries buffered overrides a concurrent redirect
      inst_ready = 1'b0;
      step();
      check32("pre_rst_valid", 32'(inst_valid), 32'd1);
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      step();
      rst = 1'b0; redirect_valid = 1'b0;
      exp_q.delete();
      check32("mid_rst_valid", 32'(inst_valid), 32'd0);
      check32("mid_rst_adr", rom_adr, 32'h0);
      step();
      check32("mid_rst_idle_valid", 32'(inst_valid), 32'd0);
      check32("mid_rst_idle_adr", rom_adr, 32'h0);
      step();
      check32("mid_rst_run_valid", 32'(inst_valid), 32'd1);
      inst_ready = 1'b1;
      exp_q.push_back(ent(32'h00));
      step();

      // en=0 drains the buffer, then redirect in IDLE waits for en
      en = 1'b0;
      exp_q.push_back(ent(32'h04)); exp_q.push_back(ent(32'h08));
      step(); step();
      check32("drain_valid", 32'(inst_valid), 32'd0);
      check32("drain_adr", rom_adr, 32'h0C);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      step();
      redirect_valid = 1'b0;
      check32("idle_redir_adr", rom_adr, 32'h100);
      step();
      check32("idle_redir_valid", 32'(inst_valid), 32'd0);
      check32("idle_redir_hold", rom_adr, 32'h100);
      en = 1'b1;
      exp_q.push_back(ent(32'h100));
      step(); step();
      check32("idle_resume_valid", 32'(inst_valid), 32'd1);
      step();
      check32("final_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
